// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, a debug port that
// the core write port pre-empts, and a post-reset zeroing sweep.
module regfile_mp #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int AW             = $clog2(NREGS),
  parameter int NRD            = 2,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [AW-1:0]       dbg_addr_i,
  input  logic [XLEN-1:0]     dbg_wdata_i,
  output logic                dbg_ack_o,
  output logic [XLEN-1:0]     dbg_rdata_o,
  output logic                clr_busy_o
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} main_state_e;
  typedef enum logic {D_IDLE = 1'b0, D_ACK = 1'b1} dbg_state_e;

  main_state_e     main_q;
  dbg_state_e      dbg_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            clr_busy_q;
  logic            dbg_ack_q;
  logic [XLEN-1:0] dbg_rdata_q;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            wr_zero_s;
  logic            dbg_zero_s;
  logic            core_wr_s;
  logic            clr_wr_s;
  logic            dbg_grant_s;
  logic            dbg_wr_s;
  logic [XLEN-1:0] dbg_rd_s;

  assign wr_zero_s   = (ZERO_REG != 0) && (waddr_i == '0);
  assign dbg_zero_s  = (ZERO_REG != 0) && (dbg_addr_i == '0);
  assign core_wr_s   = (main_q == RUN) && we_i && !wr_zero_s;
  assign clr_wr_s    = (main_q == CLEAR) && !rst;
  // A core write always wins: debug is only granted on a cycle with we_i low.
  assign dbg_grant_s = (dbg_q == D_IDLE) && (main_q == RUN) && dbg_req_i && !we_i;
  assign dbg_wr_s    = dbg_grant_s && dbg_we_i && !dbg_zero_s && !rst;
  assign dbg_rd_s    = dbg_zero_s ? '0 : regs_q[dbg_addr_i];

  // Main sweep FSM and debug handshake FSM with their registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt_q   <= '0;
      clr_busy_q  <= (CLEAR_ON_RESET != 0);
      dbg_q       <= D_IDLE;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (main_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NREGS - 1)) begin
            main_q     <= RUN;
            clr_busy_q <= 1'b0;
          end
        end
        RUN: begin
          clr_busy_q <= 1'b0;
        end
        default: begin
          main_q     <= CLEAR;
          clr_cnt_q  <= '0;
          clr_busy_q <= 1'b1;
        end
      endcase

      case (dbg_q)
        D_IDLE: begin
          if (dbg_grant_s) begin
            dbg_q     <= D_ACK;
            dbg_ack_q <= 1'b1;
            if (!dbg_we_i) begin
              dbg_rdata_q <= dbg_rd_s;
            end
          end else begin
            dbg_ack_q <= 1'b0;
          end
        end
        D_ACK: begin
          dbg_q     <= D_IDLE;
          dbg_ack_q <= 1'b0;
        end
        default: begin
          dbg_q     <= D_IDLE;
          dbg_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; the three write sources are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      regs_q[clr_cnt_q] <= '0;
    end else if (core_wr_s) begin
      regs_q[waddr_i] <= wdata_i;
    end else if (dbg_wr_s) begin
      regs_q[dbg_addr_i] <= dbg_wdata_i;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rd_s;

    assign ra_s = raddr_i[p*AW +: AW];

    // Read mux: zero register, then sweep, then bypass, then array.
    always_comb begin
      if ((ZERO_REG != 0) && (ra_s == '0)) begin
        rd_s = '0;
      end else if (main_q == CLEAR) begin
        rd_s = '0;
      end else if (we_i && (waddr_i == ra_s) && !wr_zero_s) begin
        rd_s = wdata_i;
      end else begin
        rd_s = regs_q[ra_s];
      end
    end

    assign rdata_o[p*XLEN +: XLEN] = rd_s;
  end

  assign dbg_ack_o   = dbg_ack_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign clr_busy_o  = clr_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default configuration plus a
// 4-port / 16-entry / 64-bit instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic        rst, we, dbg_req, dbg_we, dbg_ack, busy;
  logic [4:0]  waddr, dbg_addr;
  logic [31:0] wdata, dbg_wdata, dbg_rdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  // Wide instance signals
  logic         b_rst, b_we, b_dbg_req, b_dbg_we, b_dbg_ack, b_busy;
  logic [3:0]   b_waddr, b_dbg_addr;
  logic [63:0]  b_wdata, b_dbg_wdata, b_dbg_rdata;
  logic [15:0]  b_raddr;
  logic [255:0] b_rdata;

  regfile_mp dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack),
    .dbg_rdata_o(dbg_rdata), .clr_busy_o(busy)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) dut_b (
    .clk(clk), .rst(b_rst), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .raddr_i(b_raddr), .rdata_o(b_rdata), .dbg_req_i(b_dbg_req), .dbg_we_i(b_dbg_we),
    .dbg_addr_i(b_dbg_addr), .dbg_wdata_i(b_dbg_wdata), .dbg_ack_o(b_dbg_ack),
    .dbg_rdata_o(b_dbg_rdata), .clr_busy_o(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Architectural view: reg 0 is 0, an enabled write is visible the same cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return mdl[a];
  endfunction

  task automatic commit();
    if (we && waddr != 5'd0) mdl[waddr] = wdata;
    adv();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      adv();
    end
  endtask

  task automatic dbg_tx(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input int exp_lat, input string nm, output logic [31:0] rd);
    int lat;
    logic got;
    lat = 0;
    got = 1'b0;
    dbg_req = 1'b1; dbg_we = w; dbg_addr = a; dbg_wdata = d;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dbg_ack) begin
        got = 1'b1;
        break;
      end
      lat++;
      adv();
    end
    dbg_req = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    rd = dbg_rdata;
    if (got && w && a != 5'd0) mdl[a] = d;
    adv();
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    logic [63:0] bv [16];

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd5,  32'h00000001, 5'd5,  5'd3,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0};
    vecs[5] = '{1'b1, 5'd30, 32'h11111111, 5'd31, 5'd30, 32'hCAFEF00D, 32'h11111111};
    vecs[6] = '{1'b0, 5'd30, 32'h00000000, 5'd30, 5'd31, 32'h11111111, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 5'd5,  32'h5555AAAA, 5'd5,  5'd5,  32'h5555AAAA, 32'h5555AAAA};
    vecs[8] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd31, 32'h5555AAAA, 32'hCAFEF00D};

    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 10'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    b_rst = 1'b1; b_we = 1'b0; b_waddr = 4'd0; b_wdata = 64'd0; b_raddr = 16'd0;
    b_dbg_req = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = 4'd0; b_dbg_wdata = 64'd0;

    // Power-on reset and sweep
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd1);
    chk("reset ack", 64'(dbg_ack), 64'd0);
    chk("reset dbg_rdata", 64'(dbg_rdata), 64'd0);
    count_busy(n);
    chk("initial sweep length", 64'(n), 64'd32);
    adv();
    clear_model();

    // Directed write/bypass table
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr = {vecs[i].r1, vecs[i].r0};
      @(negedge clk);
      chk($sformatf("vec%0d port0", i), 64'(rdata[31:0]), 64'(vecs[i].e0));
      chk($sformatf("vec%0d port1", i), 64'(rdata[63:32]), 64'(vecs[i].e1));
      commit();
    end

    // Random core traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic [4:0] r0, r1;
      we = 1'($urandom_range(1, 0));
      waddr = 5'($urandom);
      wdata = $urandom;
      r0 = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom);
      r1 = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom);
      raddr = {r1, r0};
      @(negedge clk);
      chk($sformatf("rand%0d port0", i), 64'(rdata[31:0]), 64'(ref_read(r0)));
      chk($sformatf("rand%0d port1", i), 64'(rdata[63:32]), 64'(ref_read(r1)));
      commit();
    end
    we = 1'b0;

    // Debug held off while the core writes
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; waddr = 5'd9; wdata = 32'h90000000 + 32'(i);
      @(negedge clk);
      chk($sformatf("arb no ack %0d", i), 64'(dbg_ack), 64'd0);
      commit();
    end
    we = 1'b0;
    dbg_tx(1'b1, 5'd7, 32'hA5A5A5A5, 1, "arb write", rd);
    raddr = {5'd9, 5'd7};
    @(negedge clk);
    chk("arb reg7 port0", 64'(rdata[31:0]), 64'hA5A5A5A5);
    chk("arb reg9 port1", 64'(rdata[63:32]), 64'h90000004);
    adv();
    dbg_tx(1'b0, 5'd7, 32'd0, 1, "dbg read7", rd);
    chk("dbg read7 data", 64'(rd), 64'hA5A5A5A5);
    @(negedge clk);
    chk("dbg rdata hold", 64'(dbg_rdata), 64'hA5A5A5A5);
    adv();

    // Zero register from debug and from core
    dbg_tx(1'b1, 5'd0, 32'h00001234, 1, "dbg write r0", rd);
    dbg_tx(1'b0, 5'd0, 32'd0, 1, "dbg read r0", rd);
    chk("dbg read r0 data", 64'(rd), 64'd0);
    we = 1'b1; waddr = 5'd0; wdata = 32'h00001234; raddr = 10'd0;
    @(negedge clk);
    chk("core r0 bypass", rdata, 64'd0);
    commit();
    we = 1'b0;
    @(negedge clk);
    chk("core r0 after", rdata, 64'd0);
    adv();

    // Debug writes do not bypass to the read ports
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd20; dbg_wdata = 32'h20202020;
    raddr = {5'd20, 5'd20};
    @(negedge clk);
    chk("dbg no bypass", 64'(rdata[31:0]), 64'(mdl[20]));
    adv();
    @(negedge clk);
    chk("dbg write ack", 64'(dbg_ack), 64'd1);
    chk("dbg write visible", 64'(rdata[31:0]), 64'h20202020);
    dbg_req = 1'b0;
    mdl[20] = 32'h20202020;
    adv();

    // Reset sweep after preload; core write mid-sweep is dropped
    dbg_tx(1'b0, 5'd7, 32'd0, 1, "preload read7", rd);
    rst = 1'b1; adv(); rst = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 5) begin
        we = 1'b1; waddr = 5'd12; wdata = 32'hFFFFFFFF; raddr = {5'd7, 5'd12};
      end else begin
        we = 1'b0; raddr = {5'd12, 5'd7};
      end
      @(negedge clk);
      if (c == 0) begin
        chk("sweep0 dbg_rdata", 64'(dbg_rdata), 64'd0);
        chk("sweep0 ack", 64'(dbg_ack), 64'd0);
        chk("sweep0 read7", 64'(rdata[31:0]), 64'd0);
      end
      if (c == 5) chk("sweep5 no bypass", 64'(rdata[31:0]), 64'd0);
      if (!busy) break;
      n++;
      adv();
    end
    we = 1'b0;
    chk("reset sweep length", 64'(n), 64'd32);
    adv();
    clear_model();
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      @(negedge clk);
      chk($sformatf("cleared r%0d port0", i), 64'(rdata[31:0]), 64'd0);
      chk($sformatf("cleared r%0d port1", 31 - i), 64'(rdata[63:32]), 64'd0);
      adv();
    end

    // Reset at sweep cycle 10 restarts the sweep
    rst = 1'b1; adv(); rst = 1'b0;
    repeat (10) adv();
    rst = 1'b1; adv(); rst = 1'b0;
    count_busy(n);
    chk("restart sweep length", 64'(n), 64'd32);
    adv();

    // Reset in a grant cycle suppresses the ack; debug waits out the sweep
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h44444444;
    rst = 1'b1; adv(); rst = 1'b0; dbg_req = 1'b0;
    chk("rst at grant no ack", 64'(dbg_ack), 64'd0);
    clear_model();
    dbg_tx(1'b1, 5'd3, 32'h33333333, 33, "dbg during clear", rd);
    raddr = {5'd4, 5'd3};
    @(negedge clk);
    chk("dbg clear write r3", 64'(rdata[31:0]), 64'h33333333);
    chk("dbg rst write r4", 64'(rdata[63:32]), 64'd0);
    adv();

    // Reset in the ack cycle drops the ack next cycle
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    adv();
    dbg_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("ack before rst", 64'(dbg_ack), 64'd1);
    adv();
    rst = 1'b0;
    chk("ack dropped by rst", 64'(dbg_ack), 64'd0);

    // Wide instance: 16-entry sweep and four distinct read ports
    b_rst = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!b_busy) break;
      n++;
      adv();
    end
    chk("wide sweep length", 64'(n), 64'd16);
    adv();
    for (int i = 0; i < 16; i++) bv[i] = {32'hB0000000 + 32'(i), 32'(i) * 32'h01010101};
    for (int i = 1; i < 16; i += 5) begin
      b_we = 1'b1; b_waddr = 4'(i); b_wdata = bv[i];
      adv();
    end
    b_we = 1'b1; b_waddr = 4'd15; b_wdata = bv[15];
    adv();
    b_we = 1'b0;
    b_raddr = {4'd15, 4'd11, 4'd6, 4'd1};
    @(negedge clk);
    chk("wide port0 r1",  b_rdata[63:0],    bv[1]);
    chk("wide port1 r6",  b_rdata[127:64],  bv[6]);
    chk("wide port2 r11", b_rdata[191:128], bv[11]);
    chk("wide port3 r15", b_rdata[255:192], bv[15]);
    adv();
    b_raddr = {4'd6, 4'd0, 4'd15, 4'd2};
    @(negedge clk);
    chk("wide port0 r2",  b_rdata[63:0],    64'd0);
    chk("wide port1 r15", b_rdata[127:64],  bv[15]);
    chk("wide port2 r0",  b_rdata[191:128], 64'd0);
    chk("wide port3 r6",  b_rdata[255:192], bv[6]);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
